// File: rtl/vec_pipe_pkg.sv
// ============================================================================
// Module   : vec_pipe_pkg
// Brief    : Shared types and constants for the vector pipeline skid stage.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package vec_pipe_pkg;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_BUSY  = 2'd1,
        S_FULL  = 2'd2
    } skid_state_t;

    localparam int OCC_WIDTH = 2;

endpackage

`default_nettype wire

// File: rtl/vec_skid_buffer.sv
// ============================================================================
// Module   : vec_skid_buffer
// Brief    : Two-entry elastic stage with registered in_ready; optional stall
//            counter enabled by VEC_SKID_STALL_CNT_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module vec_skid_buffer
    import vec_pipe_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [OCC_WIDTH-1:0] occupancy
`ifdef VEC_SKID_STALL_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0] stall_cnt
`endif
);

    skid_state_t          r_state;
    logic [WIDTH-1:0]     r_main;
    logic [WIDTH-1:0]     r_skid;
    logic                 r_out_valid;
    logic                 r_in_ready;
    logic [OCC_WIDTH-1:0] r_occ;

    logic w_in_xfer;
    logic w_out_xfer;

    assign w_in_xfer  = in_valid && r_in_ready;
    assign w_out_xfer = r_out_valid && out_ready;

    // All outputs are registered so that in_ready never sees out_ready combinationally.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_EMPTY;
            r_main      <= '0;
            r_skid      <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_occ       <= '0;
        end else if (flush) begin
            r_state     <= S_EMPTY;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_occ       <= '0;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_in_xfer) begin
                        r_state     <= S_BUSY;
                        r_main      <= in_data;
                        r_out_valid <= 1'b1;
                        r_occ       <= OCC_WIDTH'(1);
                    end
                end
                S_BUSY: begin
                    if (w_in_xfer && w_out_xfer) begin
                        r_main <= in_data;
                    end else if (w_in_xfer) begin
                        r_state    <= S_FULL;
                        r_skid     <= in_data;
                        r_in_ready <= 1'b0;
                        r_occ      <= OCC_WIDTH'(2);
                    end else if (w_out_xfer) begin
                        r_state     <= S_EMPTY;
                        r_out_valid <= 1'b0;
                        r_occ       <= '0;
                    end
                end
                S_FULL: begin
                    // Skid word moves up behind the consumed head, preserving order.
                    if (w_out_xfer) begin
                        r_state    <= S_BUSY;
                        r_main     <= r_skid;
                        r_in_ready <= 1'b1;
                        r_occ      <= OCC_WIDTH'(1);
                    end
                end
                default: begin
                    r_state     <= S_EMPTY;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_occ       <= '0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_main;
    assign occupancy = r_occ;

`ifdef VEC_SKID_STALL_CNT_EN
    logic [CNT_WIDTH-1:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            r_stall_cnt <= '0;
        end else if (r_out_valid && !out_ready && (r_stall_cnt != {CNT_WIDTH{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    logic [CNT_WIDTH-1:0] w_unused_cnt;
    assign w_unused_cnt = '0;
`endif

endmodule

`default_nettype wire
